// File: rtl/mmul_result_unload.sv
// Streams the 256-bit Montgomery multiply result to the host as WORDS words of W bits,
// LS word first, rotating the selected result register one word per handshake.
module mmul_result_unload #(
  parameter int unsigned WORDS = 16,
  parameter int unsigned W     = 16,
  parameter int unsigned CW    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mmul_rdy,
  input  logic         src_sel,
  input  logic [W-1:0] regc_word,
  input  logic [W-1:0] regd_word,
  output logic         regc_cyc,
  output logic         regd_cyc,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  localparam logic [CW-1:0] LastCnt = CW'(WORDS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StSend,
    StRot,
    StFin
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;
  // Resets high so a level already present at reset release is not taken as a start.
  logic          rdy_prev_q, rdy_prev_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          regc_cyc_q, regc_cyc_d;
  logic          regd_cyc_q, regd_cyc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          start;

  assign start = mmul_rdy & ~rdy_prev_q;

  // Next-state and registered-output computation for the unload sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    rdy_prev_d  = mmul_rdy;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    regc_cyc_d  = 1'b0;
    regd_cyc_d  = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sel_d   = src_sel;
          cnt_d   = '0;
          state_d = StCapture;
        end
      end
      StCapture: begin
        out_data_d  = sel_q ? regd_word : regc_word;
        out_valid_d = 1'b1;
        out_last_d  = (cnt_q == LastCnt);
        state_d     = StSend;
      end
      StSend: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          // Pulse is registered, so it is high for exactly the ROT cycle.
          regc_cyc_d  = ~sel_q;
          regd_cyc_d  = sel_q;
          state_d     = StRot;
        end
      end
      StRot: begin
        if (cnt_q == LastCnt) begin
          state_d = StFin;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = StCapture;
        end
      end
      StFin: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered copy of (state != IDLE), aligned with state_q.
    busy_d = (state_d != StIdle);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sel_q       <= 1'b0;
      rdy_prev_q  <= 1'b1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      regc_cyc_q  <= 1'b0;
      regd_cyc_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      rdy_prev_q  <= rdy_prev_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      regc_cyc_q  <= regc_cyc_d;
      regd_cyc_q  <= regd_cyc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign regc_cyc  = regc_cyc_q;
  assign regd_cyc  = regd_cyc_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mmul_result_unload.sv
// Bench for mmul_result_unload: rotating C/D register models, a word scoreboard,
// a table of unload scenarios and hand-written reset sequences.
module tb_mmul_result_unload;

  localparam int unsigned WORDS = 16;
  localparam int unsigned W     = 16;
  localparam int unsigned CW    = 4;

  logic         clk = 1'b0;
  logic         rst, mmul_rdy, src_sel, out_ready, realign;
  logic [W-1:0] regc_word, regd_word, out_data;
  logic         regc_cyc, regd_cyc, out_valid, out_last, busy, done;

  logic [W-1:0]  c_vals[WORDS];
  logic [W-1:0]  d_vals[WORDS];
  logic [CW-1:0] c_ptr, d_ptr;

  int n_vec  = 0;
  int n_miss = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic sel;
    int   stall_idx;
    int   stall_len;
    logic toggle;
    int   exp_cycles;
    int   exp_cpul;
    int   exp_dpul;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  mmul_result_unload #(.WORDS(WORDS), .W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mmul_rdy  (mmul_rdy),
    .src_sel   (src_sel),
    .regc_word (regc_word),
    .regd_word (regd_word),
    .regc_cyc  (regc_cyc),
    .regd_cyc  (regd_cyc),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  // Result registers modelled as fixed contents with a rotating read pointer.
  assign regc_word = c_vals[c_ptr];
  assign regd_word = d_vals[d_ptr];

  always @(posedge clk) begin
    if (realign) begin
      c_ptr <= '0;
      d_ptr <= '0;
    end else begin
      if (regc_cyc) c_ptr <= c_ptr + CW'(1);
      if (regd_cyc) d_ptr <= d_ptr + CW'(1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int t = 0, widx = 0, stall_cnt = 0, tog = 0;
    int first_valid = -1, done_t = -1, cpul = 0, dpul = 0, ndone = 0;
    logic [W-1:0] e;
    for (int i = 0; i < int'(WORDS); i++) exp_q.push_back(v.sel ? d_vals[i] : c_vals[i]);
    src_sel   = v.sel;
    mmul_rdy  = 1'b1;
    out_ready = 1'b1;
    while (t < 400 && !(done_t >= 0 && t >= done_t + 3)) begin
      step();
      t++;
      if (regc_cyc) cpul++;
      if (regd_cyc) dpul++;
      if (done) begin
        ndone++;
        if (done_t < 0) done_t = t;
      end
      if (out_valid && first_valid < 0) first_valid = t;
      check("last qualified by valid", 32'(out_last & ~out_valid), 32'd0);
      if (v.toggle) begin
        if (tog == 1) begin
          mmul_rdy = 1'b1;
          tog = 2;
        end else if (tog == 0 && widx == 3 && out_valid) begin
          mmul_rdy = 1'b0;
          src_sel  = ~v.sel;
          tog = 1;
        end
      end
      out_ready = 1'b1;
      if (out_valid && widx == v.stall_idx && stall_cnt < v.stall_len) begin
        out_ready = 1'b0;
        if (exp_q.size() > 0) check("stall hold data", 32'(out_data), 32'(exp_q[0]));
        check("no rotate in stall", 32'({regc_cyc, regd_cyc}), 32'd0);
        stall_cnt++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra word", 32'(widx), 32'(WORDS));
        end else begin
          e = exp_q.pop_front();
          check("word data", 32'(out_data), 32'(e));
          check("word last", 32'(out_last), 32'(widx == int'(WORDS) - 1));
        end
        widx++;
      end
    end
    mmul_rdy  = 1'b0;
    src_sel   = 1'b0;
    out_ready = 1'b0;
    check("word count", 32'(widx), 32'(WORDS));
    check("regc_cyc pulses", 32'(cpul), 32'(v.exp_cpul));
    check("regd_cyc pulses", 32'(dpul), 32'(v.exp_dpul));
    check("done pulses", 32'(ndone), 32'd1);
    check("start to done cycles", 32'(done_t), 32'(v.exp_cycles));
    check("first valid latency", 32'(first_valid), 32'd2);
    check("C alignment", 32'(c_ptr), 32'd0);
    check("D alignment", 32'(d_ptr), 32'd0);
    check("idle after done", 32'(busy), 32'd0);
    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int hs, t;
    logic [W-1:0] e;

    vecs[0] = '{sel: 1'b0, stall_idx: -1, stall_len: 0, toggle: 1'b0,
                exp_cycles: 50, exp_cpul: 16, exp_dpul: 0};
    vecs[1] = '{sel: 1'b1, stall_idx: 7, stall_len: 5, toggle: 1'b0,
                exp_cycles: 55, exp_cpul: 0, exp_dpul: 16};
    vecs[2] = '{sel: 1'b0, stall_idx: -1, stall_len: 0, toggle: 1'b1,
                exp_cycles: 50, exp_cpul: 16, exp_dpul: 0};
    vecs[3] = '{sel: 1'b1, stall_idx: 0, stall_len: 2, toggle: 1'b1,
                exp_cycles: 52, exp_cpul: 0, exp_dpul: 16};
    vecs[4] = '{sel: 1'b0, stall_idx: 15, stall_len: 3, toggle: 1'b0,
                exp_cycles: 53, exp_cpul: 16, exp_dpul: 0};
    for (int i = 0; i < int'(WORDS); i++) begin
      c_vals[i] = W'(i);
      d_vals[i] = W'(16'hA000 + i);
    end

    // Reset with mmul_rdy already high: must stay idle after release.
    rst = 1'b1; mmul_rdy = 1'b1; src_sel = 1'b0; out_ready = 1'b0; realign = 1'b1;
    repeat (3) step();
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_last", 32'(out_last), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset cyc", 32'({regc_cyc, regd_cyc}), 32'd0);
    check("reset busy/done", 32'({busy, done}), 32'd0);
    rst = 1'b0; realign = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rdy high at release idle", 32'({busy, out_valid}), 32'd0);
    end
    mmul_rdy = 1'b0;
    step();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset after the 4th handshake.
    for (int i = 0; i < int'(WORDS); i++) exp_q.push_back(c_vals[i]);
    src_sel = 1'b0; mmul_rdy = 1'b1; out_ready = 1'b1;
    hs = 0; t = 0;
    while (hs < 4 && t < 200) begin
      step();
      t++;
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        check("pre-reset word", 32'(out_data), 32'(e));
        hs++;
      end
    end
    check("handshakes before reset", 32'(hs), 32'd4);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset cyc", 32'({regc_cyc, regd_cyc}), 32'd0);
    check("mid reset done/last", 32'({done, out_last}), 32'd0);
    for (int i = 0; i < 60; i++) begin
      step();
      check("quiet after reset", 32'({done, busy, out_valid}), 32'd0);
    end
    exp_q.delete();
    mmul_rdy = 1'b0; realign = 1'b1;
    step();
    realign = 1'b0;
    step();

    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
